// File: rtl/id_ex_stage_reg_if.sv
// id_ex_stage_reg_if
// Bundles everything that crosses the ID/EX boundary: the decoded ID-slot
// instruction, the global freeze/flush controls, the registered EX-slot copy,
// the load-use hazard signal and the two event counters.
//   master : the surrounding pipeline (drives id_*, freeze, flush)
//   slave  : the ID/EX stage register (drives ex_*, hazard_stall, counters)
interface id_ex_stage_reg_if;
    logic        freeze;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [3:0]  id_exe_cmd;
    logic [1:0]  id_br_type;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        id_wb_en;
    logic        id_is_imm;
    logic        id_one_input;
    logic [4:0]  id_src1;
    logic [4:0]  id_src2;
    logic [4:0]  id_dest;
    logic [31:0] id_val1;
    logic [31:0] id_val2;
    logic [15:0] id_imm;

    logic        ex_valid;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_wb_en;
    logic        ex_is_imm;
    logic [3:0]  ex_exe_cmd;
    logic [1:0]  ex_br_type;
    logic [4:0]  ex_dest;
    logic [4:0]  ex_src1;
    logic [4:0]  ex_src2;
    logic [31:0] ex_pc;
    logic [31:0] ex_val1;
    logic [31:0] ex_val2;
    logic [31:0] ex_imm;
    logic        hazard_stall;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    modport master (
        output freeze, flush, id_valid, id_pc, id_exe_cmd, id_br_type,
               id_mem_read, id_mem_write, id_wb_en, id_is_imm, id_one_input,
               id_src1, id_src2, id_dest, id_val1, id_val2, id_imm,
        input  ex_valid, ex_mem_read, ex_mem_write, ex_wb_en, ex_is_imm,
               ex_exe_cmd, ex_br_type, ex_dest, ex_src1, ex_src2,
               ex_pc, ex_val1, ex_val2, ex_imm,
               hazard_stall, stall_count, flush_count
    );

    modport slave (
        input  freeze, flush, id_valid, id_pc, id_exe_cmd, id_br_type,
               id_mem_read, id_mem_write, id_wb_en, id_is_imm, id_one_input,
               id_src1, id_src2, id_dest, id_val1, id_val2, id_imm,
        output ex_valid, ex_mem_read, ex_mem_write, ex_wb_en, ex_is_imm,
               ex_exe_cmd, ex_br_type, ex_dest, ex_src1, ex_src2,
               ex_pc, ex_val1, ex_val2, ex_imm,
               hazard_stall, stall_count, flush_count
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg
// ID/EX pipeline register with load-use hazard detection.
// Ports:
//   clk  : pipeline clock, all state updates on the rising edge
//   rst  : synchronous active-high reset, loads a bubble and clears counters
//   bus  : id_ex_stage_reg_if.slave -- ID-slot inputs, freeze/flush, EX-slot
//          outputs, combinational hazard_stall, saturating stall/flush counters
// Edge priority: rst > freeze > flush > hazard_stall > load.
module id_ex_stage_reg (
    input  logic                  clk,
    input  logic                  rst,
    id_ex_stage_reg_if.slave      bus
);
    typedef struct packed {
        logic        valid;
        logic        mem_read;
        logic        mem_write;
        logic        wb_en;
        logic        is_imm;
        logic [3:0]  exe_cmd;
        logic [1:0]  br_type;
        logic [4:0]  dest;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [31:0] pc;
        logic [31:0] val1;
        logic [31:0] val2;
        logic [31:0] imm;
    } ex_t;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    ex_t         ex_reg, ex_next, bubble;
    logic [15:0] stall_count_reg, stall_count_next;
    logic [15:0] flush_count_reg, flush_count_next;
    logic [1:0]  src_match;
    logic [1:0]  src_used;
    logic        hazard_raw;

    // A bubble must look like "no branch" (br_type 3), not BEZ (0).
    always_comb begin
        bubble         = '0;
        bubble.br_type = 2'd3;
    end

    // Operand 0 is src1, operand 1 is src2; src2 only matters when the
    // instruction actually reads two registers.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            if (gi == 0) begin : g_s1
                assign src_match[gi] = (bus.id_src1 == ex_reg.dest);
                assign src_used[gi]  = 1'b1;
            end else begin : g_s2
                assign src_match[gi] = (bus.id_src2 == ex_reg.dest);
                assign src_used[gi]  = ~bus.id_one_input;
            end
        end
    endgenerate

    // r0 is never a real destination, so a load into it cannot cause a hazard.
    assign hazard_raw = bus.id_valid & ex_reg.valid & ex_reg.mem_read &
                        (ex_reg.dest != 5'd0) & (|(src_match & src_used));

    // A squashed instruction must not also hold up the front end.
    assign bus.hazard_stall = hazard_raw & ~bus.flush;

    always_comb begin
        ex_next          = ex_reg;
        stall_count_next = stall_count_reg;
        flush_count_next = flush_count_reg;
        if (!bus.freeze) begin
            // Invalid ID slots become bubbles too so no stray control leaks in.
            if (bus.flush || bus.hazard_stall || !bus.id_valid) begin
                ex_next = bubble;
            end else begin
                ex_next.valid     = 1'b1;
                ex_next.mem_read  = bus.id_mem_read;
                ex_next.mem_write = bus.id_mem_write;
                ex_next.wb_en     = bus.id_wb_en;
                ex_next.is_imm    = bus.id_is_imm;
                ex_next.exe_cmd   = bus.id_exe_cmd;
                ex_next.br_type   = bus.id_br_type;
                ex_next.dest      = bus.id_dest;
                ex_next.src1      = bus.id_src1;
                ex_next.src2      = bus.id_src2;
                ex_next.pc        = bus.id_pc;
                ex_next.val1      = bus.id_val1;
                ex_next.val2      = bus.id_val2;
                ex_next.imm       = {{16{bus.id_imm[15]}}, bus.id_imm};
            end
            if (bus.flush && flush_count_reg != COUNT_MAX)
                flush_count_next = flush_count_reg + 16'd1;
            if (bus.hazard_stall && stall_count_reg != COUNT_MAX)
                stall_count_next = stall_count_reg + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_reg          <= bubble;
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            ex_reg          <= ex_next;
            stall_count_reg <= stall_count_next;
            flush_count_reg <= flush_count_next;
        end
    end

    assign bus.ex_valid     = ex_reg.valid;
    assign bus.ex_mem_read  = ex_reg.mem_read;
    assign bus.ex_mem_write = ex_reg.mem_write;
    assign bus.ex_wb_en     = ex_reg.wb_en;
    assign bus.ex_is_imm    = ex_reg.is_imm;
    assign bus.ex_exe_cmd   = ex_reg.exe_cmd;
    assign bus.ex_br_type   = ex_reg.br_type;
    assign bus.ex_dest      = ex_reg.dest;
    assign bus.ex_src1      = ex_reg.src1;
    assign bus.ex_src2      = ex_reg.src2;
    assign bus.ex_pc        = ex_reg.pc;
    assign bus.ex_val1      = ex_reg.val1;
    assign bus.ex_val2      = ex_reg.val2;
    assign bus.ex_imm       = ex_reg.imm;
    assign bus.stall_count  = stall_count_reg;
    assign bus.flush_count  = flush_count_reg;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;
    logic [15:0] exp_stall;
    logic [15:0] exp_flush;

    id_ex_stage_reg_if bus ();

    id_ex_stage_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        bus.freeze = 0; bus.flush = 0; bus.id_valid = 0; bus.id_pc = '0;
        bus.id_exe_cmd = '0; bus.id_br_type = 2'd3; bus.id_mem_read = 0;
        bus.id_mem_write = 0; bus.id_wb_en = 0; bus.id_is_imm = 0;
        bus.id_one_input = 0; bus.id_src1 = '0; bus.id_src2 = '0;
        bus.id_dest = '0; bus.id_val1 = '0; bus.id_val2 = '0; bus.id_imm = '0;
    endtask

    task automatic set_ld(input logic [4:0] dest, input logic [31:0] pc);
        clear_id();
        bus.id_valid = 1; bus.id_mem_read = 1; bus.id_wb_en = 1; bus.id_is_imm = 1;
        bus.id_one_input = 1; bus.id_src1 = 5'd1; bus.id_dest = dest;
        bus.id_pc = pc; bus.id_val1 = 32'd100; bus.id_imm = 16'h0008;
    endtask

    task automatic set_op(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                          input logic one_in, input logic mem_wr, input logic [31:0] pc);
        clear_id();
        bus.id_valid = 1; bus.id_src1 = s1; bus.id_src2 = s2; bus.id_dest = d;
        bus.id_one_input = one_in; bus.id_mem_write = mem_wr; bus.id_wb_en = ~mem_wr;
        bus.id_exe_cmd = 4'd1; bus.id_pc = pc; bus.id_val1 = 32'd7; bus.id_val2 = 32'd8;
    endtask

    task automatic test_reset();
        clear_id();
        rst = 1; tick(); rst = 0;
        exp_stall = 0; exp_flush = 0;
        $display("reset: ex_valid=%0d br=%0d", bus.ex_valid, bus.ex_br_type);
        total_cnt++; if (bus.ex_valid !== 1'b0) $display("FAIL reset_valid got %0h want 0", bus.ex_valid); else pass_cnt++;
        total_cnt++; if (bus.ex_br_type !== 2'd3) $display("FAIL reset_br got %0h want 3", bus.ex_br_type); else pass_cnt++;
        total_cnt++; if (bus.stall_count !== 16'd0) $display("FAIL reset_stall_cnt got %0h want 0", bus.stall_count); else pass_cnt++;
        total_cnt++; if (bus.flush_count !== 16'd0) $display("FAIL reset_flush_cnt got %0h want 0", bus.flush_count); else pass_cnt++;
        total_cnt++; if (bus.ex_pc !== 32'd0) $display("FAIL reset_pc got %0h want 0", bus.ex_pc); else pass_cnt++;
    endtask

    task automatic test_load();
        clear_id();
        bus.id_valid = 1; bus.id_exe_cmd = 4'd0; bus.id_is_imm = 1; bus.id_one_input = 1;
        bus.id_wb_en = 1; bus.id_src1 = 5'd2; bus.id_dest = 5'd3; bus.id_pc = 32'h104;
        bus.id_val1 = 32'd5; bus.id_imm = 16'hFFF0; bus.id_br_type = 2'd3;
        tick();
        $display("load: ex_imm=%h ex_val1=%0d", bus.ex_imm, bus.ex_val1);
        total_cnt++; if (bus.ex_valid !== 1'b1) $display("FAIL load_valid got %0h want 1", bus.ex_valid); else pass_cnt++;
        total_cnt++; if (bus.ex_imm !== 32'hFFFFFFF0) $display("FAIL load_imm got %h want fffffff0", bus.ex_imm); else pass_cnt++;
        total_cnt++; if (bus.ex_val1 !== 32'd5) $display("FAIL load_val1 got %0h want 5", bus.ex_val1); else pass_cnt++;
        total_cnt++; if (bus.ex_exe_cmd !== 4'd0) $display("FAIL load_cmd got %0h want 0", bus.ex_exe_cmd); else pass_cnt++;
        total_cnt++; if (bus.ex_pc !== 32'h104) $display("FAIL load_pc got %h want 104", bus.ex_pc); else pass_cnt++;
        total_cnt++; if (bus.ex_dest !== 5'd3) $display("FAIL load_dest got %0d want 3", bus.ex_dest); else pass_cnt++;
        bus.id_imm = 16'h0012; bus.id_exe_cmd = 4'd9; bus.id_br_type = 2'd1;
        tick();
        $display("load2: ex_imm=%h cmd=%0d", bus.ex_imm, bus.ex_exe_cmd);
        total_cnt++; if (bus.ex_imm !== 32'h00000012) $display("FAIL load_imm_pos got %h want 00000012", bus.ex_imm); else pass_cnt++;
        total_cnt++; if (bus.ex_exe_cmd !== 4'd9) $display("FAIL load_cmd9 got %0h want 9", bus.ex_exe_cmd); else pass_cnt++;
        total_cnt++; if (bus.ex_br_type !== 2'd1) $display("FAIL load_br got %0h want 1", bus.ex_br_type); else pass_cnt++;
    endtask

    task automatic test_invalid_bubble();
        set_op(5'd1, 5'd2, 5'd9, 0, 1, 32'h300);
        bus.id_valid = 0; bus.id_wb_en = 1; bus.id_br_type = 2'd2;
        tick();
        $display("invalid: ex_valid=%0d mw=%0d br=%0d", bus.ex_valid, bus.ex_mem_write, bus.ex_br_type);
        total_cnt++; if (bus.ex_valid !== 1'b0) $display("FAIL inv_valid got %0h want 0", bus.ex_valid); else pass_cnt++;
        total_cnt++; if (bus.ex_mem_write !== 1'b0) $display("FAIL inv_mw got %0h want 0", bus.ex_mem_write); else pass_cnt++;
        total_cnt++; if (bus.ex_wb_en !== 1'b0) $display("FAIL inv_wb got %0h want 0", bus.ex_wb_en); else pass_cnt++;
        total_cnt++; if (bus.ex_br_type !== 2'd3) $display("FAIL inv_br got %0h want 3", bus.ex_br_type); else pass_cnt++;
        total_cnt++; if (bus.ex_pc !== 32'd0) $display("FAIL inv_pc got %h want 0", bus.ex_pc); else pass_cnt++;
    endtask

    task automatic test_load_use();
        set_ld(5'd4, 32'h400);
        tick();
        set_op(5'd4, 5'd5, 5'd6, 0, 0, 32'h404);
        #1;
        $display("load_use: hazard=%0d", bus.hazard_stall);
        total_cnt++; if (bus.hazard_stall !== 1'b1) $display("FAIL lu_hazard got %0h want 1", bus.hazard_stall); else pass_cnt++;
        tick();
        exp_stall = exp_stall + 1;
        total_cnt++; if (bus.ex_valid !== 1'b0) $display("FAIL lu_bubble got %0h want 0", bus.ex_valid); else pass_cnt++;
        total_cnt++; if (bus.ex_mem_read !== 1'b0) $display("FAIL lu_bubble_mr got %0h want 0", bus.ex_mem_read); else pass_cnt++;
        total_cnt++; if (bus.stall_count !== exp_stall) $display("FAIL lu_stall_cnt got %0h want %0h", bus.stall_count, exp_stall); else pass_cnt++;
        total_cnt++; if (bus.hazard_stall !== 1'b0) $display("FAIL lu_hazard_drop got %0h want 0", bus.hazard_stall); else pass_cnt++;
        tick();
        $display("load_use: ADD in EX valid=%0d dest=%0d", bus.ex_valid, bus.ex_dest);
        total_cnt++; if (bus.ex_valid !== 1'b1) $display("FAIL lu_add_valid got %0h want 1", bus.ex_valid); else pass_cnt++;
        total_cnt++; if (bus.ex_dest !== 5'd6) $display("FAIL lu_add_dest got %0d want 6", bus.ex_dest); else pass_cnt++;
        total_cnt++; if (bus.ex_val2 !== 32'd8) $display("FAIL lu_add_val2 got %0h want 8", bus.ex_val2); else pass_cnt++;
        total_cnt++; if (bus.stall_count !== exp_stall) $display("FAIL lu_cnt_hold got %0h want %0h", bus.stall_count, exp_stall); else pass_cnt++;
    endtask

    task automatic test_store_hazard();
        set_ld(5'd4, 32'h500);
        tick();
        set_op(5'd1, 5'd4, 5'd0, 0, 1, 32'h504);
        #1;
        $display("store: hazard=%0d", bus.hazard_stall);
        total_cnt++; if (bus.hazard_stall !== 1'b1) $display("FAIL st_src2 got %0h want 1", bus.hazard_stall); else pass_cnt++;
        set_op(5'd1, 5'd4, 5'd7, 1, 0, 32'h504);
        #1;
        $display("addi one_input: hazard=%0d", bus.hazard_stall);
        total_cnt++; if (bus.hazard_stall !== 1'b0) $display("FAIL addi_one_in got %0h want 1'b0", bus.hazard_stall); else pass_cnt++;
        tick();
        total_cnt++; if (bus.ex_dest !== 5'd7) $display("FAIL addi_loaded got %0d want 7", bus.ex_dest); else pass_cnt++;
        total_cnt++; if (bus.stall_count !== exp_stall) $display("FAIL addi_no_cnt got %0h want %0h", bus.stall_count, exp_stall); else pass_cnt++;
        set_ld(5'd0, 32'h600);
        tick();
        set_op(5'd0, 5'd0, 5'd8, 0, 0, 32'h604);
        #1;
        $display("ld r0: hazard=%0d", bus.hazard_stall);
        total_cnt++; if (bus.hazard_stall !== 1'b0) $display("FAIL ld_r0 got %0h want 0", bus.hazard_stall); else pass_cnt++;
        tick();
        total_cnt++; if (bus.ex_valid !== 1'b1) $display("FAIL ld_r0_load got %0h want 1", bus.ex_valid); else pass_cnt++;
    endtask

    task automatic test_flush_hazard();
        clear_id();
        rst = 1; tick(); rst = 0;
        exp_stall = 0; exp_flush = 0;
        set_ld(5'd4, 32'h700);
        tick();
        set_op(5'd4, 5'd2, 5'd3, 0, 0, 32'h704);
        bus.flush = 1;
        #1;
        total_cnt++; if (bus.hazard_stall !== 1'b0) $display("FAIL fl_hazard_masked got %0h want 0", bus.hazard_stall); else pass_cnt++;
        tick();
        exp_flush = exp_flush + 1;
        $display("flush: ex_valid=%0d flush_cnt=%0d stall_cnt=%0d", bus.ex_valid, bus.flush_count, bus.stall_count);
        total_cnt++; if (bus.ex_valid !== 1'b0) $display("FAIL fl_bubble got %0h want 0", bus.ex_valid); else pass_cnt++;
        total_cnt++; if (bus.flush_count !== 16'd1) $display("FAIL fl_flush_cnt got %0h want 1", bus.flush_count); else pass_cnt++;
        total_cnt++; if (bus.stall_count !== 16'd0) $display("FAIL fl_stall_cnt got %0h want 0", bus.stall_count); else pass_cnt++;
        bus.flush = 0;
    endtask

    task automatic test_freeze();
        set_ld(5'd4, 32'h800);
        tick();
        set_op(5'd4, 5'd2, 5'd3, 0, 0, 32'h804);
        bus.freeze = 1;
        for (int i = 0; i < 3; i++) begin
            bus.flush = (i == 2);
            tick();
            $display("freeze cycle %0d: ex_pc=%h", i, bus.ex_pc);
            total_cnt++; if (bus.ex_pc !== 32'h800) $display("FAIL frz_pc got %h want 800", bus.ex_pc); else pass_cnt++;
            total_cnt++; if (bus.ex_mem_read !== 1'b1) $display("FAIL frz_mr got %0h want 1", bus.ex_mem_read); else pass_cnt++;
            total_cnt++; if (bus.stall_count !== exp_stall) $display("FAIL frz_stall got %0h want %0h", bus.stall_count, exp_stall); else pass_cnt++;
            total_cnt++; if (bus.flush_count !== exp_flush) $display("FAIL frz_flush got %0h want %0h", bus.flush_count, exp_flush); else pass_cnt++;
        end
        clear_id();
        tick();
    endtask

    task automatic test_saturation();
        force dut.stall_count_reg = 16'hFFFE;
        #1;
        release dut.stall_count_reg;
        for (int i = 0; i < 2; i++) begin
            set_ld(5'd4, 32'h900);
            tick();
            set_op(5'd4, 5'd1, 5'd2, 0, 0, 32'h904);
            tick();
            $display("saturate %0d: stall_cnt=%h", i, bus.stall_count);
            total_cnt++; if (bus.stall_count !== 16'hFFFF) $display("FAIL sat_stall got %h want ffff", bus.stall_count); else pass_cnt++;
        end
        exp_stall = 16'hFFFF;
    endtask

    task automatic test_reset_mid_stall();
        set_ld(5'd4, 32'hA00);
        tick();
        set_op(5'd4, 5'd1, 5'd2, 0, 0, 32'hA04);
        #1;
        total_cnt++; if (bus.hazard_stall !== 1'b1) $display("FAIL rms_hazard got %0h want 1", bus.hazard_stall); else pass_cnt++;
        rst = 1; tick(); rst = 0;
        exp_stall = 0; exp_flush = 0;
        $display("reset mid-stall: hazard=%0d ex_valid=%0d", bus.hazard_stall, bus.ex_valid);
        total_cnt++; if (bus.hazard_stall !== 1'b0) $display("FAIL rms_hazard_clr got %0h want 0", bus.hazard_stall); else pass_cnt++;
        total_cnt++; if (bus.stall_count !== 16'd0) $display("FAIL rms_stall got %0h want 0", bus.stall_count); else pass_cnt++;
    endtask

    task automatic test_reset_freeze();
        set_op(5'd1, 5'd2, 5'd3, 0, 0, 32'hB00);
        bus.id_br_type = 2'd0;
        tick();
        bus.flush = 1;
        tick();
        bus.flush = 0;
        set_op(5'd1, 5'd2, 5'd3, 0, 0, 32'hB04);
        bus.id_br_type = 2'd0;
        tick();
        total_cnt++; if (bus.flush_count !== 16'd1) $display("FAIL rf_pre_flush got %0h want 1", bus.flush_count); else pass_cnt++;
        bus.freeze = 1; bus.flush = 1; rst = 1;
        tick();
        rst = 0; bus.freeze = 0; bus.flush = 0;
        $display("reset+freeze: valid=%0d br=%0d cnts=%0d/%0d", bus.ex_valid, bus.ex_br_type, bus.stall_count, bus.flush_count);
        total_cnt++; if (bus.ex_valid !== 1'b0) $display("FAIL rf_valid got %0h want 0", bus.ex_valid); else pass_cnt++;
        total_cnt++; if (bus.ex_br_type !== 2'd3) $display("FAIL rf_br got %0h want 3", bus.ex_br_type); else pass_cnt++;
        total_cnt++; if (bus.flush_count !== 16'd0) $display("FAIL rf_flush got %0h want 0", bus.flush_count); else pass_cnt++;
        total_cnt++; if (bus.stall_count !== 16'd0) $display("FAIL rf_stall got %0h want 0", bus.stall_count); else pass_cnt++;
        total_cnt++; if (bus.ex_pc !== 32'd0) $display("FAIL rf_pc got %h want 0", bus.ex_pc); else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0; exp_stall = 0; exp_flush = 0;
        rst = 1;
        clear_id();
        #2;
        test_reset();
        test_load();
        test_invalid_bubble();
        test_load_use();
        test_store_hazard();
        test_flush_hazard();
        test_freeze();
        test_saturation();
        test_reset_mid_stall();
        test_reset_freeze();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/id_ex_stage_reg.md
ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
REQ-001 SHALL have a single clock domain; reset is synchronous and active-high.
REQ-002 SHALL expose these ports (name  direction  width  meaning):
  clk  in  1  pipeline clock, all state on rising edge
  rst  in  1  synchronous active-high reset
  freeze  in  1  global hold (memory stall); holds all state
  flush  in  1  branch taken in EX; squash instruction entering EX
  id_valid  in  1  ID holds a real instruction
  id_pc  in  32  PC+4 of ID instruction
  id_exe_cmd  in  4  ALU command from control decode
  id_br_type  in  2  0=BEZ, 1=BNE, 2=JMP, 3=none
  id_mem_read, id_mem_write, id_wb_en, id_is_imm, id_one_input  in  1 each  decode flags
  id_src1, id_src2, id_dest  in  5 each  register addresses
  id_val1, id_val2  in  32 each  register-file read data
  id_imm  in  16  raw immediate field
  ex_valid, ex_mem_read, ex_mem_write, ex_wb_en, ex_is_imm  out  1 each  registered copies
  ex_exe_cmd  out  4;  ex_br_type  out  2;  ex_dest, ex_src1, ex_src2  out  5 each
  ex_pc, ex_val1, ex_val2, ex_imm  out  32 each  (ex_imm sign-extended)
  hazard_stall  out  1  combinational; tells IF/ID and PC to hold
  stall_count, flush_count  out  16 each  saturating event counters

Function
REQ-003 hazard_stall SHALL = id_valid & ex_valid & ex_mem_read & (ex_dest != 0) & (id_src1 == ex_dest | (!id_one_input & id_src2 == ex_dest)).
REQ-004 hazard_stall SHALL be forced 0 while flush=1 (squashed instruction causes no stall).
REQ-005 Per rising edge, priority SHALL be rst > freeze > flush > hazard_stall > load.
REQ-006 freeze=1: every register and counter SHALL hold; flush is not sampled (upstream keeps flush asserted until freeze drops).
REQ-007 flush=1 or hazard_stall=1 (freeze=0): SHALL load a bubble: ex_valid=0, ex_wb_en=0, ex_mem_read=0, ex_mem_write=0, ex_br_type=3, all other ex_* = 0.
REQ-008 Load (none of above): every ex_* SHALL take its id_* value one cycle later; ex_valid=id_valid; ex_imm={{16{id_imm[15]}},id_imm}.
REQ-009 id_valid=0 on load SHALL produce the same bubble as REQ-007 (no side-effect controls pass while invalid).
REQ-010 Latency ID->EX SHALL be exactly 1 cycle; a stalled instruction re-presents on id_* and enters EX the cycle after hazard_stall drops.
REQ-011 stall_count SHALL +1 on each non-frozen edge with hazard_stall=1; flush_count SHALL +1 on each non-frozen edge with flush=1 and the upstream ID-slot... counted once per edge; both saturate at 16'hFFFF (no wrap).
REQ-012 Simultaneous flush and hazard condition SHALL insert one bubble and increment flush_count only.
REQ-013 Load-use on r0 (ex_dest=0) SHALL NOT stall.

Reset
REQ-014 rst=1 at a rising edge SHALL set all ex_* to the bubble values of REQ-007 and both counters to 0, regardless of freeze/flush.
REQ-015 rst asserted mid-stall SHALL clear state; hazard_stall then evaluates 0 (ex_valid=0) the next cycle.

Verification
REQ-016 Load: id_valid=1, ADDI, id_imm=16'hFFF0, id_val1=5 -> next cycle ex_valid=1, ex_imm=32'hFFFFFFF0, ex_val1=5, ex_exe_cmd=0.
REQ-017 Load-use: EX holds LD ex_dest=4; ID ADD src1=4 -> hazard_stall=1, next EX bubble, stall_count=1; ADD enters EX one cycle later.
REQ-018 ST in ID with src2=4 (one_input=0) after LD dest 4 -> stall; ADDI with src2=4, one_input=1 -> no stall; LD dest 0 -> no stall.
REQ-019 flush=1 with hazard condition present -> bubble, flush_count=1, stall_count=0; freeze=1 for 3 cycles -> all outputs and counters unchanged.
REQ-020 stall_count preloaded to 16'hFFFF by repeated stalls -> further stall keeps 16'hFFFF; rst=1 with freeze=1 -> counters 0, ex_br_type=3, ex_valid=0.
